// File: rtl/r5p_soc_mem_arb_pkg.sv
// r5p_soc_pkg: types shared by the memory arbiter, its tag pipeline and the bench.
package r5p_soc_pkg;

  // Requester identities; the value doubles as the per-port index.
  typedef enum logic {
    ARB_IFU = 1'b0,
    ARB_LSU = 1'b1
  } arb_id_t;

  // One entry of the read-return tag pipeline.
  typedef struct packed {
    logic    vld;
    arb_id_t owner;
  } arb_tag_t;

  localparam int ARB_NUM = 2;

  // The requester that is not 'id'.
  function automatic arb_id_t arb_other(input arb_id_t id);
    return (id == ARB_IFU) ? ARB_LSU : ARB_IFU;
  endfunction

endpackage

// File: rtl/r5p_soc_mem_arb_if.sv
// r5p_bus_if: simple valid/ready memory bus. 'man' drives the request,
// 'sub' answers with ready and read data.
interface r5p_bus_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int BW = DW/8
) ();
  logic          vld;
  logic          wen;
  logic [AW-1:0] adr;
  logic [BW-1:0] ben;
  logic [DW-1:0] wdt;
  logic [DW-1:0] rdt;
  logic          rdy;

  modport man (output vld, wen, adr, ben, wdt, input  rdt, rdy);
  modport sub (input  vld, wen, adr, ben, wdt, output rdt, rdy);
endinterface

// File: rtl/r5p_soc_mem.sv
// r5p_soc_mem: single-port word memory with byte enables, always ready
// unless stalled, read data registered one cycle after a read transfer.
module r5p_soc_mem #(
  parameter int AW = 12,
  parameter int DW = 32,
  parameter int BW = DW/8
) (
  input  logic   clk,
  input  logic   stall,
  r5p_bus_if.sub s
);

  localparam int OFS   = $clog2(BW);
  localparam int WORDS = 2 ** (AW - OFS);

  logic [AW-OFS-1:0] idx;
  logic              xfer;
  logic [DW-1:0]     rd_word;
  logic              unused_adr;

  assign idx        = s.adr[AW-1:OFS];
  assign unused_adr = ^s.adr[OFS-1:0];
  assign xfer       = s.vld & ~stall;
  assign s.rdy      = ~stall;
  assign s.rdt      = rd_word;

  for (genvar gi = 0; gi < BW; gi++) begin : g_lane
    logic [7:0] lane_reg [WORDS];
    logic [7:0] rd_reg;

    // Byte lane: enabled write, and read data captured only on read transfers.
    always_ff @(posedge clk) begin
      if (xfer && s.wen && s.ben[gi]) begin
        lane_reg[idx] <= s.wdt[8*gi +: 8];
      end
      if (xfer && !s.wen) begin
        rd_reg <= lane_reg[idx];
      end
    end

    assign rd_word[8*gi +: 8] = rd_reg;
  end

endmodule

// File: rtl/r5p_soc_mem_arb_tag_pipe.sv
// r5p_soc_arb_tag_pipe: LAT-deep shift register of read tags. A tag enters
// on the transfer cycle and reaches tag_out exactly when the memory returns
// the matching read data.
module r5p_soc_arb_tag_pipe
  import r5p_soc_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  arb_tag_t tag_in,
  output arb_tag_t tag_out
);

  for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
    arb_tag_t stage_in;
    arb_tag_t stage_reg;

    if (gi == 0) begin : g_head
      assign stage_in = tag_in;
    end else begin : g_tail
      assign stage_in = g_stage[gi-1].stage_reg;
    end

    // Advance one stage per cycle; reset drops every in-flight tag.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        stage_reg <= '0;
      end else begin
        stage_reg <= stage_in;
      end
    end
  end

  assign tag_out = g_stage[LAT-1].stage_reg;

endmodule

// File: rtl/r5p_soc_mem_arb.sv
// r5p_soc_mem_arb: arbitrates instruction fetch (s_ifu) and load/store (s_lsu)
// onto one memory port (m). A stalled grant is locked until it completes;
// read data is routed back by a tag pipeline matching the memory latency.
// Contention policy: fixed priority (LSU wins) by default; define
// R5P_SOC_MEM_ARB_RR_EN for round-robin.
module r5p_soc_mem_arb
  import r5p_soc_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int BW  = DW/8,
  parameter int LAT = 1
) (
  input  logic   clk,
  input  logic   rst,
  r5p_bus_if.sub s_ifu,
  r5p_bus_if.sub s_lsu,
  r5p_bus_if.man m
);

  if (LAT < 1 || LAT > 2) begin : g_bad_lat
    $error("r5p_soc_mem_arb: LAT=%0d outside legal range 1..2", LAT);
  end
  if (BW * 8 != DW || AW < 1) begin : g_bad_width
    $error("r5p_soc_mem_arb: BW must be DW/8 and AW positive");
  end

  logic     lock_reg;
  arb_id_t  owner_reg;
  arb_id_t  gnt;
  logic     sel_lsu;
  logic     mst_vld;
  logic     xfer;
  arb_tag_t tag_push;
  arb_tag_t tag_ret;

`ifdef R5P_SOC_MEM_ARB_RR_EN
  arb_id_t  last_reg;
`endif

  // Grant: a held lock wins, then the contention policy, then the lone requester.
  always_comb begin
    gnt = ARB_IFU;
    if (lock_reg) begin
      gnt = owner_reg;
    end else if (s_ifu.vld && s_lsu.vld) begin
`ifdef R5P_SOC_MEM_ARB_RR_EN
      gnt = arb_other(last_reg);
`else
      gnt = ARB_LSU;
`endif
    end else if (s_lsu.vld) begin
      gnt = ARB_LSU;
    end
  end

  // Request path is a pure mux; reset forces the handshake quiet.
  assign sel_lsu   = (gnt == ARB_LSU);
  assign mst_vld   = rst & (sel_lsu ? s_lsu.vld : s_ifu.vld);
  assign xfer      = mst_vld & m.rdy;
  assign m.vld     = mst_vld;
  assign m.wen     = sel_lsu ? s_lsu.wen : s_ifu.wen;
  assign m.adr     = sel_lsu ? s_lsu.adr : s_ifu.adr;
  assign m.ben     = sel_lsu ? s_lsu.ben : s_ifu.ben;
  assign m.wdt     = sel_lsu ? s_lsu.wdt : s_ifu.wdt;
  assign s_ifu.rdy = rst & ~sel_lsu & m.rdy;
  assign s_lsu.rdy = rst &  sel_lsu & m.rdy;

  // Lock onto a stalled grant; any other outcome (transfer or dropped vld) releases it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_reg  <= 1'b0;
      owner_reg <= ARB_IFU;
    end else begin
      lock_reg <= mst_vld & ~m.rdy;
      if (mst_vld && !m.rdy) begin
        owner_reg <= gnt;
      end
    end
  end

`ifdef R5P_SOC_MEM_ARB_RR_EN
  // Remember who completed the last transfer so contention alternates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_reg <= ARB_IFU;
    end else if (xfer) begin
      last_reg <= gnt;
    end
  end
`endif

  // Only read transfers produce returning data worth routing.
  assign tag_push = '{vld: xfer & ~m.wen, owner: gnt};

  r5p_soc_arb_tag_pipe #(
    .LAT (LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_push),
    .tag_out (tag_ret)
  );

  logic [DW-1:0] port_rdt [ARB_NUM];

  for (genvar gi = 0; gi < ARB_NUM; gi++) begin : g_port
    logic          hit;
    logic [DW-1:0] rdt_q_reg;

    assign hit          = tag_ret.vld && (tag_ret.owner == arb_id_t'(gi));
    assign port_rdt[gi] = hit ? m.rdt : rdt_q_reg;

    // Hold the port's last returned word until its next read comes back.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rdt_q_reg <= '0;
      end else if (hit) begin
        rdt_q_reg <= m.rdt;
      end
    end
  end

  assign s_ifu.rdt = port_rdt[0];
  assign s_lsu.rdt = port_rdt[1];

endmodule

// File: tb/tb_r5p_soc_mem_arb.sv
// tb_r5p_soc_mem_arb: arbiter in front of r5p_soc_mem (AW=12, LAT=1).
// A transaction-level model (grant rules, lock, read queue, word memory)
// is compared with the DUT every cycle; directed steps add literal checks.
module tb_r5p_soc_mem_arb;
  import r5p_soc_pkg::*;

  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int BW  = 4;
  localparam int LAT = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic stall = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  r5p_bus_if #(.AW(AW), .DW(DW), .BW(BW)) ifu_bus ();
  r5p_bus_if #(.AW(AW), .DW(DW), .BW(BW)) lsu_bus ();
  r5p_bus_if #(.AW(AW), .DW(DW), .BW(BW)) mem_bus ();

  r5p_soc_mem_arb #(.AW(AW), .DW(DW), .BW(BW), .LAT(LAT)) dut (
    .clk   (clk),
    .rst   (rst_n),
    .s_ifu (ifu_bus),
    .s_lsu (lsu_bus),
    .m     (mem_bus)
  );

  r5p_soc_mem #(.AW(AW), .DW(DW), .BW(BW)) u_mem (
    .clk   (clk),
    .stall (stall),
    .s     (mem_bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct {
    int          due;
    int          port;
    logic [31:0] data;
  } rd_t;

  int          hold_g = -1;
  int          cyc    = 0;
  logic [31:0] mdl_rdt [2];
  logic [31:0] mdl_mem [int];
  rd_t         pend [$];
`ifdef R5P_SOC_MEM_ARB_RR_EN
  int          last_g = 0;
`endif

  always @(negedge clk) begin : model_cmp
    int          g;
    int          widx;
    logic        v0, v1, exp_vld, mrdy, gwen;
    logic [11:0] gadr;
    logic [31:0] gwdt, word;
    logic [3:0]  gben;
    cyc++;
    if (!rst_n) begin
      hold_g = -1;
`ifdef R5P_SOC_MEM_ARB_RR_EN
      last_g = 0;
`endif
      pend.delete();
      mdl_rdt[0] = 32'h0;
      mdl_rdt[1] = 32'h0;
      check("rst_m_vld",   32'(mem_bus.vld), 32'h0);
      check("rst_ifu_rdy", 32'(ifu_bus.rdy), 32'h0);
      check("rst_lsu_rdy", 32'(lsu_bus.rdy), 32'h0);
      check("rst_ifu_rdt", ifu_bus.rdt, 32'h0);
      check("rst_lsu_rdt", lsu_bus.rdt, 32'h0);
    end else begin
      v0   = ifu_bus.vld;
      v1   = lsu_bus.vld;
      mrdy = !stall;
      if (hold_g >= 0) g = hold_g;
      else if (v0 && v1) begin
`ifdef R5P_SOC_MEM_ARB_RR_EN
        g = 1 - last_g;
`else
        g = 1;
`endif
      end
      else if (v1) g = 1;
      else if (v0) g = 0;
      else g = -1;
      exp_vld = (g == 0) ? v0 : (g == 1) ? v1 : 1'b0;
      gwen = (g == 1) ? lsu_bus.wen : ifu_bus.wen;
      gadr = (g == 1) ? lsu_bus.adr : ifu_bus.adr;
      gwdt = (g == 1) ? lsu_bus.wdt : ifu_bus.wdt;
      gben = (g == 1) ? lsu_bus.ben : ifu_bus.ben;

      check("m_vld", 32'(mem_bus.vld), 32'(exp_vld));
      if (exp_vld) begin
        check("m_wen", 32'(mem_bus.wen), 32'(gwen));
        check("m_adr", 32'(mem_bus.adr), 32'(gadr));
        check("m_wdt", mem_bus.wdt, gwdt);
        check("m_ben", 32'(mem_bus.ben), 32'(gben));
        check("ifu_rdy", 32'(ifu_bus.rdy), 32'((g == 0) && mrdy));
        check("lsu_rdy", 32'(lsu_bus.rdy), 32'((g == 1) && mrdy));
      end

      while (pend.size() > 0 && pend[0].due == cyc) begin
        mdl_rdt[pend[0].port] = pend[0].data;
        void'(pend.pop_front());
      end
      check("ifu_rdt", ifu_bus.rdt, mdl_rdt[0]);
      check("lsu_rdt", lsu_bus.rdt, mdl_rdt[1]);

      // Effect of the coming rising edge.
      if (exp_vld && mrdy) begin
`ifdef R5P_SOC_MEM_ARB_RR_EN
        last_g = g;
`endif
        hold_g = -1;
        widx = int'(gadr[11:2]);
        word = mdl_mem.exists(widx) ? mdl_mem[widx] : 32'h0;
        if (gwen) begin
          for (int b = 0; b < 4; b++) if (gben[b]) word[8*b +: 8] = gwdt[8*b +: 8];
          mdl_mem[widx] = word;
        end else begin
          pend.push_back('{due: cyc + LAT, port: g, data: word});
        end
      end else begin
        hold_g = exp_vld ? g : -1;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [11:0] pre_adr [4] = '{12'h000, 12'h004, 12'h008, 12'h010};
  logic [31:0] pre_dat [4] = '{32'h00004e37, 32'h11111111, 32'h22222222, 32'hcafef00d};
`ifdef R5P_SOC_MEM_ARB_RR_EN
  logic        exp_lsu_win [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
  logic        exp_lsu_win [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int p);
    if (p == 0) begin
      ifu_bus.vld = 1'b0; ifu_bus.wen = 1'b0; ifu_bus.adr = '0; ifu_bus.wdt = '0; ifu_bus.ben = '0;
    end else begin
      lsu_bus.vld = 1'b0; lsu_bus.wen = 1'b0; lsu_bus.adr = '0; lsu_bus.wdt = '0; lsu_bus.ben = '0;
    end
  endtask

  task automatic drive(input int p, input logic wen, input logic [11:0] adr,
                       input logic [31:0] wdt, input logic [3:0] ben);
    if (p == 0) begin
      ifu_bus.vld = 1'b1; ifu_bus.wen = wen; ifu_bus.adr = adr; ifu_bus.wdt = wdt; ifu_bus.ben = ben;
    end else begin
      lsu_bus.vld = 1'b1; lsu_bus.wen = wen; lsu_bus.adr = adr; lsu_bus.wdt = wdt; lsu_bus.ben = ben;
    end
  endtask

  initial begin
    idle(0);
    idle(1);
    rst_n = 1'b0;
    drive(0, 1'b0, 12'h000, 32'h0, 4'hf);
    tick();
    #3;
    check("reset_m_vld",   32'(mem_bus.vld), 32'h0);
    check("reset_ifu_rdy", 32'(ifu_bus.rdy), 32'h0);
    check("reset_ifu_rdt", ifu_bus.rdt, 32'h0);
    tick();
    rst_n = 1'b1;
    idle(0);

    // Preload words through the LSU.
    for (int i = 0; i < 4; i++) begin
      drive(1, 1'b1, pre_adr[i], pre_dat[i], 4'hf);
      tick();
    end
    idle(1);
    tick();

    // Lone IFU read of 0x0.
    drive(0, 1'b0, 12'h000, 32'h0, 4'hf);
    #3;
    check("ifu_req_m_vld", 32'(mem_bus.vld), 32'h1);
    tick();
    idle(0);
    #3;
    check("ifu_rd0", ifu_bus.rdt, 32'h00004e37);
    check("ifu_rd0_lsu_quiet", lsu_bus.rdt, 32'h0);
    tick();

    // Lone LSU read of 0x10.
    drive(1, 1'b0, 12'h010, 32'h0, 4'hf);
    tick();
    idle(1);
    #3;
    check("lsu_rd10", lsu_bus.rdt, 32'hcafef00d);
    check("lsu_rd10_ifu_hold", ifu_bus.rdt, 32'h00004e37);
    tick();

    // Six cycles of contention.
    drive(0, 1'b0, 12'h000, 32'h0, 4'hf);
    drive(1, 1'b0, 12'h004, 32'h0, 4'hf);
    for (int i = 0; i < 6; i++) begin
      #3;
      check($sformatf("contend%0d_lsu_rdy", i), 32'(lsu_bus.rdy), 32'(exp_lsu_win[i]));
      check($sformatf("contend%0d_ifu_rdy", i), 32'(ifu_bus.rdy), 32'(!exp_lsu_win[i]));
      tick();
    end
    idle(0);
    idle(1);
    tick();

    // Partial write then read back.
    drive(1, 1'b1, 12'h010, 32'hdeadbeef, 4'b0011);
    tick();
    idle(1);
    drive(0, 1'b0, 12'h010, 32'h0, 4'hf);
    tick();
    idle(0);
    #3;
    check("ben_merge", ifu_bus.rdt, 32'hcafebeef);
    tick();

    // Stalled IFU grant stays locked while the LSU waits.
    stall = 1'b1;
    drive(0, 1'b0, 12'h008, 32'h0, 4'hf);
    #3;
    check("lock_c1_ifu_rdy", 32'(ifu_bus.rdy), 32'h0);
    tick();
    drive(1, 1'b0, 12'h010, 32'h0, 4'hf);
    #3;
    check("lock_c2_adr", 32'(mem_bus.adr), 32'h008);
    check("lock_c2_lsu_rdy", 32'(lsu_bus.rdy), 32'h0);
    tick();
    #3;
    check("lock_c3_adr", 32'(mem_bus.adr), 32'h008);
    tick();
    stall = 1'b0;
    #3;
    check("lock_c4_ifu_rdy", 32'(ifu_bus.rdy), 32'h1);
    check("lock_c4_lsu_rdy", 32'(lsu_bus.rdy), 32'h0);
    tick();
    idle(0);
    #3;
    check("lock_c5_lsu_rdy", 32'(lsu_bus.rdy), 32'h1);
    check("lock_c5_adr", 32'(mem_bus.adr), 32'h010);
    check("lock_c5_ifu_rdt", ifu_bus.rdt, 32'h22222222);
    tick();
    idle(1);
    #3;
    check("lock_c6_lsu_rdt", lsu_bus.rdt, 32'hcafebeef);
    tick();

    // Alternating reads ifu@0, lsu@4, ifu@8.
    drive(0, 1'b0, 12'h000, 32'h0, 4'hf);
    tick();
    idle(0);
    drive(1, 1'b0, 12'h004, 32'h0, 4'hf);
    #3;
    check("alt_ifu0", ifu_bus.rdt, 32'h00004e37);
    check("alt_lsu_hold", lsu_bus.rdt, 32'hcafebeef);
    tick();
    idle(1);
    drive(0, 1'b0, 12'h008, 32'h0, 4'hf);
    #3;
    check("alt_lsu4", lsu_bus.rdt, 32'h11111111);
    check("alt_ifu_hold", ifu_bus.rdt, 32'h00004e37);
    tick();
    idle(0);
    #3;
    check("alt_ifu8", ifu_bus.rdt, 32'h22222222);
    check("alt_lsu_hold2", lsu_bus.rdt, 32'h11111111);
    tick();

    // Reset one cycle after an LSU read issues.
    drive(1, 1'b0, 12'h000, 32'h0, 4'hf);
    tick();
    idle(1);
    rst_n = 1'b0;
    #3;
    check("midrst_m_vld",   32'(mem_bus.vld), 32'h0);
    check("midrst_ifu_rdy", 32'(ifu_bus.rdy), 32'h0);
    check("midrst_lsu_rdy", 32'(lsu_bus.rdy), 32'h0);
    check("midrst_ifu_rdt", ifu_bus.rdt, 32'h0);
    check("midrst_lsu_rdt", lsu_bus.rdt, 32'h0);
    tick();
    rst_n = 1'b1;
    #3;
    check("postrst_lsu_rdt0", lsu_bus.rdt, 32'h0);
    tick();
    #3;
    check("postrst_lsu_rdt1", lsu_bus.rdt, 32'h0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
